// File: rtl/li_sequencer_if.sv
// Handshake bundle between decode, li_sequencer and execute.
// master = decode/execute side, slave = the sequencer.
interface li_sequencer_if #(
  parameter int REG_AW = 5
);
  logic              req_valid;
  logic              req_ready;
  logic [REG_AW-1:0] req_rd;
  logic [31:0]       req_imm;
  logic              uop_valid;
  logic              uop_ready;
  logic [1:0]        uop_kind;
  logic [REG_AW-1:0] uop_rd;
  logic [REG_AW-1:0] uop_rs;
  logic [15:0]       uop_imm;
  logic              done;
  logic              busy;

  modport master (
    output req_valid, req_rd, req_imm, uop_ready,
    input  req_ready, uop_valid, uop_kind,
    input  uop_rd, uop_rs, uop_imm, done, busy
  );

  modport slave (
    input  req_valid, req_rd, req_imm, uop_ready,
    output req_ready, uop_valid, uop_kind,
    output uop_rd, uop_rs, uop_imm, done, busy
  );
endinterface

// File: rtl/li_sequencer.sv
// Expands li rd, imm32 into LUI / ORI / ADDIU micro-ops.
// Optional ADDIU shortcut: define LI_ADDIU_OPT_EN.
module li_sequencer #(
  parameter int REG_AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  li_sequencer_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE_HI = 2'd1,
    ISSUE_LO = 2'd2
  } state_e;

  localparam logic [1:0] K_LUI   = 2'b00;
  localparam logic [1:0] K_ORI   = 2'b01;
  localparam logic [1:0] K_ADDIU = 2'b10;

  state_e            state_q, state_d;
  logic [1:0]        kind_q, kind_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [REG_AW-1:0] rs_q, rs_d;
  logic [15:0]       imm_q, imm_d;
  logic [15:0]       lo_q, lo_d;
  logic              two_q, two_d;
  logic              done_q, done_d;

  logic [15:0] hi, lo;
  logic        rd_zero;
  logic        sext_fit;
  logic        hs;

  assign hi      = bus.req_imm[31:16];
  assign lo      = bus.req_imm[15:0];
  assign rd_zero = (bus.req_rd == '0);
  assign hs      = bus.uop_ready;

`ifdef LI_ADDIU_OPT_EN
  assign sext_fit = (hi == {16{lo[15]}}) && (hi != 16'h0);
`else
  assign sext_fit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      kind_q  <= K_LUI;
      rd_q    <= '0;
      rs_q    <= '0;
      imm_q   <= '0;
      lo_q    <= '0;
      two_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      rd_q    <= rd_d;
      rs_q    <= rs_d;
      imm_q   <= imm_d;
      lo_q    <= lo_d;
      two_q   <= two_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    rd_d    = rd_q;
    rs_d    = rs_q;
    imm_d   = imm_q;
    lo_d    = lo_q;
    two_d   = two_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          rd_d  = bus.req_rd;
          rs_d  = '0;
          lo_d  = lo;
          two_d = 1'b0;
          if (rd_zero) begin
            done_d = 1'b1;
          end else if (hi == 16'h0) begin
            state_d = ISSUE_LO;
            kind_d  = K_ORI;
            imm_d   = lo;
          end else if (sext_fit) begin
            state_d = ISSUE_LO;
            kind_d  = K_ADDIU;
            imm_d   = lo;
          end else begin
            // LUI first; ORI follows only if lo carries bits
            state_d = ISSUE_HI;
            kind_d  = K_LUI;
            imm_d   = hi;
            two_d   = (lo != 16'h0);
          end
        end
      end
      ISSUE_HI: begin
        if (hs) begin
          if (two_q) begin
            state_d = ISSUE_LO;
            kind_d  = K_ORI;
            rs_d    = rd_q;
            imm_d   = lo_q;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ISSUE_LO: begin
        if (hs) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state_q == IDLE);
    bus.busy      = (state_q != IDLE);
    bus.uop_valid = (state_q != IDLE);
    bus.uop_kind  = kind_q;
    bus.uop_rd    = rd_q;
    bus.uop_rs    = rs_q;
    bus.uop_imm   = imm_q;
    bus.done      = done_q;
  end
endmodule

// File: tb/tb_li_sequencer.sv
// Directed bench for li_sequencer with hand-computed expectations.
// Checks are sampled 1 time unit after the rising edge.
module tb_li_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  li_sequencer_if #(.REG_AW(5)) bus();

  li_sequencer #(.REG_AW(5)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // {valid, kind, rd, rs, imm, done, busy, ready}
  logic [31:0] obs;
  logic [3:0]  sobs;
  logic [31:0] e;
  logic [3:0]  es;

  assign obs = {bus.uop_valid, bus.uop_kind, bus.uop_rd,
                bus.uop_rs, bus.uop_imm, bus.done,
                bus.busy, bus.req_ready};
  assign sobs = {obs[31], obs[2:0]};

  function automatic logic [31:0] act(
    input logic [1:0] k, input logic [4:0] rd,
    input logic [4:0] rs, input logic [15:0] imm);
    return {1'b1, k, rd, rs, imm, 3'b010};
  endfunction

  // idle view: {valid, done, busy, ready}
  function automatic logic [3:0] st(input logic d);
    return {1'b0, d, 1'b0, 1'b1};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] rd,
                      input logic [31:0] imm);
    bus.req_valid = 1'b1;
    bus.req_rd    = rd;
    bus.req_imm   = imm;
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_rd    = '0;
    bus.req_imm   = '0;
    bus.uop_ready = 1'b1;
    #7;
    checks++;
    if (obs !== 32'h1) begin
      errors++;
      $display("FAIL reset got %h exp %h", obs, 32'h1);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic test_two_uop();
    send(5'd8, 32'h12345678);
    e = act(2'b00, 5'd8, 5'd0, 16'h1234);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL two_lui got %h exp %h", obs, e);
    end
    step();
    e = act(2'b01, 5'd8, 5'd8, 16'h5678);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL two_ori got %h exp %h", obs, e);
    end
    step();
    es = st(1'b1);
    checks++;
    if (sobs !== es) begin
      errors++;
      $display("FAIL two_done got %h exp %h", sobs, es);
    end
    step();
    es = st(1'b0);
    checks++;
    if (sobs !== es) begin
      errors++;
      $display("FAIL two_done_clr got %h exp %h", sobs, es);
    end
  endtask

  task automatic test_single();
    send(5'd3, 32'h0000ABCD);
    e = act(2'b01, 5'd3, 5'd0, 16'hABCD);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL ori_only got %h exp %h", obs, e);
    end
    step();
    es = st(1'b1);
    checks++;
    if (sobs !== es) begin
      errors++;
      $display("FAIL ori_done got %h exp %h", sobs, es);
    end
    step();
    send(5'd3, 32'hABCD0000);
    e = act(2'b00, 5'd3, 5'd0, 16'hABCD);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL lui_only got %h exp %h", obs, e);
    end
    step();
    es = st(1'b1);
    checks++;
    if (sobs !== es) begin
      errors++;
      $display("FAIL lui_done got %h exp %h", sobs, es);
    end
    step();
  endtask

  task automatic test_addiu();
    send(5'd5, 32'hFFFF8000);
`ifdef LI_ADDIU_OPT_EN
    e = act(2'b10, 5'd5, 5'd0, 16'h8000);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL addiu got %h exp %h", obs, e);
    end
`else
    e = act(2'b00, 5'd5, 5'd0, 16'hFFFF);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL sext_lui got %h exp %h", obs, e);
    end
    step();
    e = act(2'b01, 5'd5, 5'd5, 16'h8000);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL sext_ori got %h exp %h", obs, e);
    end
`endif
    step();
    es = st(1'b1);
    checks++;
    if (sobs !== es) begin
      errors++;
      $display("FAIL sext_done got %h exp %h", sobs, es);
    end
    step();
  endtask

  task automatic test_rd_zero();
    send(5'd0, 32'hDEADBEEF);
    es = st(1'b1);
    checks++;
    if (sobs !== es) begin
      errors++;
      $display("FAIL rd0_done got %h exp %h", sobs, es);
    end
    step();
    es = st(1'b0);
    checks++;
    if (sobs !== es) begin
      errors++;
      $display("FAIL rd0_idle got %h exp %h", sobs, es);
    end
  endtask

  task automatic test_stall();
    bus.uop_ready = 1'b0;
    send(5'd8, 32'h12345678);
    // a competing request held during the stall must be ignored
    bus.req_valid = 1'b1;
    bus.req_rd    = 5'd9;
    bus.req_imm   = 32'h11112222;
    e = act(2'b00, 5'd8, 5'd0, 16'h1234);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL stall_lui[%0d] got %h exp %h", i, obs, e);
      end
      step();
    end
    bus.uop_ready = 1'b1;
    bus.req_valid = 1'b0;
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL stall_release got %h exp %h", obs, e);
    end
    step();
    e = act(2'b01, 5'd8, 5'd8, 16'h5678);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL stall_ori got %h exp %h", obs, e);
    end
    step();
    es = st(1'b1);
    checks++;
    if (sobs !== es) begin
      errors++;
      $display("FAIL stall_done got %h exp %h", sobs, es);
    end
    step();
    es = st(1'b0);
    checks++;
    if (sobs !== es) begin
      errors++;
      $display("FAIL stall_one_done got %h exp %h", sobs, es);
    end
  endtask

  task automatic test_reset_mid();
    send(5'd8, 32'h12345678);
    step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 32'h1) begin
      errors++;
      $display("FAIL rst_async got %h exp %h", obs, 32'h1);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    checks++;
    if (obs !== 32'h1) begin
      errors++;
      $display("FAIL rst_hold got %h exp %h", obs, 32'h1);
    end
    step();
    es = st(1'b0);
    checks++;
    if (sobs !== es) begin
      errors++;
      $display("FAIL rst_no_done got %h exp %h", sobs, es);
    end
    send(5'd3, 32'h0000ABCD);
    e = act(2'b01, 5'd3, 5'd0, 16'hABCD);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL rst_next got %h exp %h", obs, e);
    end
    step();
    es = st(1'b1);
    checks++;
    if (sobs !== es) begin
      errors++;
      $display("FAIL rst_next_done got %h exp %h", sobs, es);
    end
    step();
  endtask

  task automatic test_back_to_back();
    bus.req_valid = 1'b1;
    bus.req_rd    = 5'd6;
    bus.req_imm   = 32'h00000011;
    step();
    bus.req_rd    = 5'd7;
    bus.req_imm   = 32'hABCD0000;
    e = act(2'b01, 5'd6, 5'd0, 16'h0011);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL b2b_first got %h exp %h", obs, e);
    end
    step();
    es = st(1'b1);
    checks++;
    if (sobs !== es) begin
      errors++;
      $display("FAIL b2b_done_accept got %h exp %h", sobs, es);
    end
    step();
    bus.req_valid = 1'b0;
    e = act(2'b00, 5'd7, 5'd0, 16'hABCD);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL b2b_second got %h exp %h", obs, e);
    end
    step();
    es = st(1'b1);
    checks++;
    if (sobs !== es) begin
      errors++;
      $display("FAIL b2b_done2 got %h exp %h", sobs, es);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_two_uop();
    test_single();
    test_addiu();
    test_rd_zero();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
